// File: rtl/vga_pkg.sv
// Shared VGA constants: default active area, RGB565 colours and the box palette.
package vga_pkg;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;

  localparam logic [9:0] PIX_NONE = 10'h3FF;

  localparam logic [15:0] C_WHITE     = 16'hFFFF;
  localparam logic [15:0] C_RED       = 16'hF800;
  localparam logic [15:0] C_GREEN     = 16'h07E0;
  localparam logic [15:0] C_BLUE      = 16'h001F;
  localparam logic [15:0] C_YELLOW    = 16'hFFE0;
  localparam logic [15:0] C_MAGENTA   = 16'hF81F;
  localparam logic [15:0] C_CYAN      = 16'h07FF;
  localparam logic [15:0] C_ORANGE    = 16'hFC00;
  localparam logic [15:0] C_DARK_BLUE = 16'h0010;
  localparam logic [15:0] C_BLACK     = 16'h0000;

  typedef logic [2:0] color_idx_t;

  function automatic logic [15:0] palette(input color_idx_t idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_RED;
      3'd2:    c = C_GREEN;
      3'd3:    c = C_BLUE;
      3'd4:    c = C_YELLOW;
      3'd5:    c = C_MAGENTA;
      3'd6:    c = C_CYAN;
      default: c = C_ORANGE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position, direction and a one-cycle hit pulse
// when the step clamps at 0 or LIMIT.
module vga_bounce_axis #(
  parameter int LIMIT = 624,
  parameter int STEP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_step_en,
  output logic [9:0] o_pos,
  output logic       o_hit
);

  localparam logic [10:0] LIM11  = 11'(LIMIT);
  localparam logic [9:0]  STEP10 = 10'(STEP);

  logic [9:0]  r_pos;
  logic        r_dir;
  logic [10:0] w_fwd_sum;
  logic [9:0]  w_pos_nxt;
  logic        w_dir_nxt;
  logic        w_clamp;

  always_comb begin
    w_fwd_sum = {1'b0, r_pos} + {1'b0, STEP10};
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    w_clamp   = 1'b0;
    if (!r_dir) begin
      if (w_fwd_sum >= LIM11) begin
        w_pos_nxt = LIM11[9:0];
        w_dir_nxt = 1'b1;
        w_clamp   = 1'b1;
      end else begin
        w_pos_nxt = w_fwd_sum[9:0];
      end
    end else begin
      if (r_pos <= STEP10) begin
        w_pos_nxt = '0;
        w_dir_nxt = 1'b0;
        w_clamp   = 1'b1;
      end else begin
        w_pos_nxt = r_pos - STEP10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_dir <= 1'b0;
    end else if (i_step_en) begin
      r_pos <= w_pos_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  assign o_pos = r_pos;
  assign o_hit = i_step_en & w_clamp;

endmodule

// File: rtl/vga_bounce_pic.sv
// Bouncing-square picture generator with registered RGB565 output.
// Optional white frame border when VGA_BOUNCE_BORDER_EN is defined.
module vga_bounce_pic
  import vga_pkg::*;
#(
  parameter int H_VALID  = H_VALID_DEF,
  parameter int V_VALID  = V_VALID_DEF,
  parameter int BOX_SIZE = 16,
  parameter int STEP     = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pause,
  output logic [15:0] pix_data
);

  localparam logic [9:0]  H_LAST = 10'(H_VALID - 1);
  localparam logic [9:0]  V_LAST = 10'(V_VALID - 1);
  localparam logic [10:0] BOX11  = 11'(BOX_SIZE);

  logic        w_tick_match;
  logic        r_tick_match_d;
  logic        w_frame_tick;
  logic        r_upd;
  logic [9:0]  w_box_x;
  logic [9:0]  w_box_y;
  logic        w_hit_x;
  logic        w_hit_y;
  color_idx_t  r_color_idx;
  logic        w_active;
  logic        w_in_box;
  logic [15:0] w_pix_nxt;
  logic [15:0] r_pix_data;

  // Edge-detected so a held last-pixel coordinate still gives a single tick.
  assign w_tick_match = (pix_x == H_LAST) && (pix_y == V_LAST);
  assign w_frame_tick = w_tick_match & ~r_tick_match_d;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tick_match_d <= 1'b0;
      r_upd          <= 1'b0;
    end else begin
      r_tick_match_d <= w_tick_match;
      r_upd          <= w_frame_tick & ~pause;
    end
  end

  vga_bounce_axis #(.LIMIT(H_VALID - BOX_SIZE), .STEP(STEP)) u_axis_x (
    .clk       (vga_clk),
    .rst_n     (sys_rst_n),
    .i_step_en (r_upd),
    .o_pos     (w_box_x),
    .o_hit     (w_hit_x)
  );

  vga_bounce_axis #(.LIMIT(V_VALID - BOX_SIZE), .STEP(STEP)) u_axis_y (
    .clk       (vga_clk),
    .rst_n     (sys_rst_n),
    .i_step_en (r_upd),
    .o_pos     (w_box_y),
    .o_hit     (w_hit_y)
  );

  // A corner hit (both axes in one frame) still advances the colour once.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_color_idx <= '0;
    end else if (w_hit_x | w_hit_y) begin
      r_color_idx <= r_color_idx + 3'd1;
    end
  end

  assign w_active = (pix_x != PIX_NONE) && (pix_y != PIX_NONE);
  assign w_in_box = ({1'b0, pix_x} >= {1'b0, w_box_x}) &&
                    ({1'b0, pix_x} <  ({1'b0, w_box_x} + BOX11)) &&
                    ({1'b0, pix_y} >= {1'b0, w_box_y}) &&
                    ({1'b0, pix_y} <  ({1'b0, w_box_y} + BOX11));

`ifdef VGA_BOUNCE_BORDER_EN
  logic w_border;
  assign w_border = (pix_x == 10'd0) || (pix_x == H_LAST) ||
                    (pix_y == 10'd0) || (pix_y == V_LAST);
`endif

  always_comb begin
    w_pix_nxt = C_DARK_BLUE;
    if (!w_active) begin
      w_pix_nxt = C_BLACK;
    end else if (w_in_box) begin
      w_pix_nxt = palette(r_color_idx);
`ifdef VGA_BOUNCE_BORDER_EN
    end else if (w_border) begin
      w_pix_nxt = C_WHITE;
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pix_data <= 16'h0000;
    end else begin
      r_pix_data <= w_pix_nxt;
    end
  end

  assign pix_data = r_pix_data;

endmodule

// File: tb/tb_vga_bounce_pic.sv
// Randomized bench for vga_bounce_pic against a frame-level bounce model.
// Frames are compressed: one last-pixel cycle followed by blanking.
module tb_vga_bounce_pic;

  localparam int LIMX = 640 - 16;
  localparam int LIMY = 480 - 16;
  localparam int STP  = 2;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pause;
  logic [15:0] pix_data;

  int checks = 0;
  int errors = 0;

  int m_x, m_y, m_dx, m_dy, m_idx;
  int corners = 0;
  int wraps = 0;
  logic [15:0] pal [8];

  vga_bounce_pic dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pause     (pause),
    .pix_data  (pix_data)
  );

  always #20 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_idx = 0;
  endfunction

  function automatic void axis_move(inout int pos, inout int dir, input int lim, output bit hit);
    hit = 0;
    if (dir == 0) begin
      if (pos + STP >= lim) begin pos = lim; dir = 1; hit = 1; end
      else pos = pos + STP;
    end else begin
      if (pos <= STP) begin pos = 0; dir = 0; hit = 1; end
      else pos = pos - STP;
    end
  endfunction

  function automatic void model_frame(input bit p);
    bit hx, hy;
    if (!p) begin
      axis_move(m_x, m_dx, LIMX, hx);
      axis_move(m_y, m_dy, LIMY, hy);
      if (hx && hy) corners++;
      if (hx || hy) begin
        if (m_idx == 7) wraps++;
        m_idx = (m_idx + 1) % 8;
      end
    end
  endfunction

  function automatic logic [15:0] exp_pix(input int x, input int y);
    if (x == 1023 || y == 1023) return 16'h0000;
    if (x >= m_x && x < m_x + 16 && y >= m_y && y < m_y + 16) return pal[m_idx];
`ifdef VGA_BOUNCE_BORDER_EN
    if (x == 0 || x == 639 || y == 0 || y == 479) return 16'hFFFF;
`endif
    return 16'h0010;
  endfunction

  // Called at a negedge; returns at the negedge where the registered pixel is visible.
  task automatic probe(input int x, input int y, input string tag);
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(negedge vga_clk);
    chk(tag, pix_data, exp_pix(x, y));
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_x"},   dut.w_box_x, m_x);
    chk({tag, "_y"},   dut.w_box_y, m_y);
    chk({tag, "_dx"},  dut.u_axis_x.r_dir, m_dx);
    chk({tag, "_dy"},  dut.u_axis_y.r_dir, m_dy);
    chk({tag, "_idx"}, dut.r_color_idx, m_idx);
  endtask

  task automatic frame(input bit p, input string tag);
    pix_x = 10'd639;
    pix_y = 10'd479;
    pause = p;
    @(negedge vga_clk);
    chk({tag, "_lastpix"}, pix_data, exp_pix(639, 479));
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
    pause = 1'($urandom);
    @(negedge vga_clk);
    @(negedge vga_clk);
    model_frame(p);
    check_state(tag);
  endtask

  initial begin
    int x, y, n, pre_idx, pre_corners, after;
    pal[0] = 16'hFFFF; pal[1] = 16'hF800; pal[2] = 16'h07E0; pal[3] = 16'h001F;
    pal[4] = 16'hFFE0; pal[5] = 16'hF81F; pal[6] = 16'h07FF; pal[7] = 16'hFC00;

    sys_rst_n = 1'b0;
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
    pause = 1'b0;
    model_reset();
    repeat (3) @(negedge vga_clk);
    chk("rst_pix", pix_data, 16'h0000);
    check_state("rst");
    sys_rst_n = 1'b1;
    @(negedge vga_clk);

    probe(5, 5, "first_box");
    probe(100, 100, "first_bg");
    probe(1023, 1023, "first_blank");
    probe(15, 15, "box_edge_in");
    probe(16, 5, "box_edge_xout");
    probe(5, 16, "box_edge_yout");
    probe(300, 1023, "blank_y");

    for (int f = 0; f < 10; f++) frame(1'b0, "run10");
    chk("run10_x", dut.w_box_x, 20);
    chk("run10_y", dut.w_box_y, 20);
    chk("run10_idx", dut.r_color_idx, 0);
    probe(20, 20, "run10_box");
    probe(19, 20, "run10_left");
    probe(35, 35, "run10_br");
    probe(36, 35, "run10_right");

    for (int f = 0; f < 3; f++) frame(1'b1, "pause");
    chk("pause_hold_x", dut.w_box_x, 20);
    frame(1'b0, "unpause");
    chk("unpause_x", dut.w_box_x, 22);

    // Long random run: reaches edge hits, colour wraps and a simultaneous corner hit.
    n = 0;
    after = 0;
    while (n < 12000 && after < 40) begin
      pre_idx = m_idx;
      pre_corners = corners;
      frame($urandom_range(0, 7) == 0, "rand");
      if (corners != pre_corners)
        chk("corner_single_inc", dut.r_color_idx, (pre_idx + 1) % 8);
      if (corners > 0 && wraps > 0) after++;
      if ($urandom_range(0, 3) == 0) begin
        x = m_x + $urandom_range(0, 19) - 2;
        y = m_y + $urandom_range(0, 19) - 2;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        if (x > 639) x = 639;
        if (y > 479) y = 479;
        if (x == 639 && y == 479) y = 478;
        probe(x, y, "rand_near_box");
      end
      if ($urandom_range(0, 15) == 0) begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 478);
        probe(x, y, "rand_any");
      end
      n++;
    end
    chk("corner_reached", (corners > 0) ? 1 : 0, 1);
    chk("wrap_reached", (wraps > 0) ? 1 : 0, 1);

    // Asynchronous reset in the middle of a frame.
    pix_x = 10'd300;
    pix_y = 10'd200;
    @(negedge vga_clk);
    #5 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_pix", pix_data, 16'h0000);
    chk("async_rst_x", dut.w_box_x, 0);
    chk("async_rst_y", dut.w_box_y, 0);
    chk("async_rst_idx", dut.r_color_idx, 0);
    model_reset();
    @(negedge vga_clk);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    @(negedge vga_clk);
    probe(0, 240, "border_left");
    probe(639, 240, "border_right");
    probe(320, 0, "border_top");
    probe(0, 0, "corner_box");
    probe(320, 240, "post_rst_bg");
    check_state("post_rst_idle");
    frame(1'b0, "post_rst_first");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
